// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA host stager: state encoding, flag register
// constants and default sizing.
// Optional feature macro: RSA_STAGER_TIMEOUT_EN (adds the ABORT state).
package rsa_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_KICK  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_POLL  = 3'd4;
    localparam state_t ST_DRAIN = 3'd5;
`ifdef RSA_STAGER_TIMEOUT_EN
    localparam state_t ST_ABORT = 3'd6;
`endif

    localparam logic       FLAG_ADDR = 1'b0;
    localparam logic [7:0] FLAG_GO   = 8'h01;
    localparam logic [7:0] FLAG_CLR  = 8'h00;

    localparam int DEF_BUF_BYTES      = 320;
    localparam int DEF_POLL_GAP       = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/rsa_byte_packer.sv
// 32-bit <-> 8-bit holding register with a byte index. Unpack: a loaded word
// is presented byte by byte on byte_o. Pack: incoming bytes fill word_o
// starting at byte 0 (bits [7:0]).
module rsa_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        clr_i,
    input  logic        wr_step_i,
    input  logic        rd_step_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  byte_o,
    output logic [1:0]  idx_o
);

    logic [31:0] hold_q, hold_d;
    logic [1:0]  idx_q, idx_d;

    // A new word always restarts at byte 0; otherwise each step moves to the next byte.
    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (load_i) begin
            hold_d = word_i;
            idx_d  = 2'd0;
        end else if (clr_i) begin
            idx_d  = 2'd0;
        end else if (wr_step_i) begin
            idx_d  = idx_q + 2'd1;
        end else if (rd_step_i) begin
            hold_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Holding register and byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 32'd0;
            idx_q  <= 2'd0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = hold_q;
    assign byte_o = hold_q[{idx_q, 3'b000} +: 8];
    assign idx_o  = idx_q;

endmodule

// File: rtl/rsa_host_stager.sv
// RSA host stager: unpacks a 32-bit host stream into the byte-wide job
// buffer, raises the engine flag, polls until the engine clears it, then
// reads the buffer back as a 32-bit result stream.
// Optional feature macro: RSA_STAGER_TIMEOUT_EN (polling watchdog + err).
module rsa_host_stager import rsa_pkg::*; #(
    parameter int BUF_BYTES      = DEF_BUF_BYTES,
    parameter int POLL_GAP       = DEF_POLL_GAP,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_in_data,
    input  logic        s_in_valid,
    output logic        s_in_ready,
    output logic [31:0] s_out_data,
    output logic        s_out_valid,
    input  logic        s_out_ready,
    output logic [31:0] m_buf_address,
    output logic        m_buf_read,
    output logic        m_buf_write,
    output logic [7:0]  m_buf_writedata,
    input  logic [7:0]  m_buf_readdata,
    input  logic        m_buf_waitrequest,
    output logic        m_ctl_address,
    output logic        m_ctl_read,
    output logic        m_ctl_write,
    output logic [7:0]  m_ctl_writedata,
    input  logic [7:0]  m_ctl_readdata,
    input  logic        m_ctl_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             GW        = $clog2(POLL_GAP + 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(POLL_GAP - 1);
    localparam logic [31:0]    LAST_ADDR = 32'(BUF_BYTES - 1);
    localparam logic [31:0]    END_ADDR  = 32'(BUF_BYTES);

    if (BUF_BYTES < 4 || (BUF_BYTES % 4) != 0) begin : g_bad_buf
        $error("BUF_BYTES must be a non-zero multiple of 4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic [GW-1:0] gap_q;
    logic          buf_wr_q, buf_rd_q, ctl_wr_q, ctl_rd_q, out_vld_q;
    logic [7:0]    ctl_wdata_q;

    logic [31:0]   pk_word;
    logic [7:0]    pk_byte;
    logic [1:0]    pk_idx;

    logic buf_wr_done, buf_rd_done, ctl_wr_done, ctl_rd_done;
    logic in_acc, out_acc, last_byte, drain_end, flag_clear, abort_go;
    logic ctl_rd_unused;

    assign buf_wr_done = buf_wr_q & ~m_buf_waitrequest;
    assign buf_rd_done = buf_rd_q & ~m_buf_waitrequest;
    assign ctl_wr_done = ctl_wr_q & ~m_ctl_waitrequest;
    assign ctl_rd_done = ctl_rd_q & ~m_ctl_waitrequest;
    assign in_acc      = s_in_valid & s_in_ready;
    assign out_acc     = out_vld_q & s_out_ready;
    assign last_byte   = (addr_q == LAST_ADDR);
    // addr_q has already stepped past the final byte once the last group is read
    assign drain_end   = (addr_q == END_ADDR);
    assign flag_clear  = (state_q == ST_POLL) & ctl_rd_done & ~m_ctl_readdata[0];
    assign ctl_rd_unused = ^m_ctl_readdata[7:1];

`ifdef RSA_STAGER_TIMEOUT_EN
    logic [31:0] to_q;
    logic        err_q;
    logic        to_hit;
    assign to_hit = (to_q >= 32'(TIMEOUT_CYCLES));
    // Abort only when no flag read is in flight, so the bus is never left mid-transfer.
    assign abort_go = to_hit & ((state_q == ST_WAIT) |
                                ((state_q == ST_POLL) & ctl_rd_done & m_ctl_readdata[0]));
    assign err = err_q;
`else
    assign abort_go = 1'b0;
    assign err      = 1'b0;
`endif

    rsa_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (in_acc),
        .word_i    (s_in_data),
        .clr_i     (flag_clear),
        .wr_step_i ((state_q == ST_LOAD) & buf_wr_done),
        .rd_step_i ((state_q == ST_DRAIN) & buf_rd_done),
        .byte_i    (m_buf_readdata),
        .word_o    (pk_word),
        .byte_o    (pk_byte),
        .idx_o     (pk_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_acc) state_d = ST_LOAD;
            ST_LOAD:  if (buf_wr_done && last_byte) state_d = ST_KICK;
            ST_KICK:  if (ctl_wr_done) state_d = ST_WAIT;
            ST_WAIT: begin
`ifdef RSA_STAGER_TIMEOUT_EN
                if (abort_go)                state_d = ST_ABORT;
                else
`endif
                if (gap_q == GAP_LAST)       state_d = ST_POLL;
            end
            ST_POLL: begin
                if (flag_clear)              state_d = ST_DRAIN;
`ifdef RSA_STAGER_TIMEOUT_EN
                else if (abort_go)           state_d = ST_ABORT;
`endif
                else if (ctl_rd_done)        state_d = ST_WAIT;
            end
            ST_DRAIN: if (out_acc && drain_end) state_d = ST_IDLE;
`ifdef RSA_STAGER_TIMEOUT_EN
            ST_ABORT: if (ctl_wr_done) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered bus strobes, address and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= 32'd0;
            gap_q       <= '0;
            buf_wr_q    <= 1'b0;
            buf_rd_q    <= 1'b0;
            ctl_wr_q    <= 1'b0;
            ctl_rd_q    <= 1'b0;
            ctl_wdata_q <= 8'd0;
            out_vld_q   <= 1'b0;
`ifdef RSA_STAGER_TIMEOUT_EN
            to_q        <= 32'd0;
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef RSA_STAGER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (in_acc) begin
                        addr_q   <= 32'd0;
                        buf_wr_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (buf_wr_done) begin
                        addr_q <= addr_q + 32'd1;
                        if (last_byte) begin
                            buf_wr_q    <= 1'b0;
                            ctl_wr_q    <= 1'b1;
                            ctl_wdata_q <= FLAG_GO;
                        end else if (pk_idx == 2'd3) begin
                            // chain straight into the next word, or park until one arrives
                            buf_wr_q <= s_in_valid;
                        end
                    end else if (!buf_wr_q && s_in_valid) begin
                        buf_wr_q <= 1'b1;
                    end
                end
                ST_KICK: begin
                    if (ctl_wr_done) begin
                        ctl_wr_q <= 1'b0;
                        gap_q    <= '0;
`ifdef RSA_STAGER_TIMEOUT_EN
                        to_q     <= 32'd0;
`endif
                    end
                end
                ST_WAIT: begin
                    gap_q <= gap_q + 1'b1;
`ifdef RSA_STAGER_TIMEOUT_EN
                    to_q  <= to_q + 32'd1;
                    if (abort_go) begin
                        ctl_wr_q    <= 1'b1;
                        ctl_wdata_q <= FLAG_CLR;
                        err_q       <= 1'b1;
                    end else
`endif
                    if (gap_q == GAP_LAST) ctl_rd_q <= 1'b1;
                end
                ST_POLL: begin
`ifdef RSA_STAGER_TIMEOUT_EN
                    to_q <= to_q + 32'd1;
`endif
                    if (ctl_rd_done) begin
                        ctl_rd_q <= 1'b0;
                        gap_q    <= '0;
                        if (!m_ctl_readdata[0]) begin
                            addr_q   <= 32'd0;
                            buf_rd_q <= 1'b1;
                        end
`ifdef RSA_STAGER_TIMEOUT_EN
                        else if (abort_go) begin
                            ctl_wr_q    <= 1'b1;
                            ctl_wdata_q <= FLAG_CLR;
                            err_q       <= 1'b1;
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    if (buf_rd_done) begin
                        addr_q <= addr_q + 32'd1;
                        if (pk_idx == 2'd3) begin
                            buf_rd_q  <= 1'b0;
                            out_vld_q <= 1'b1;
                        end
                    end
                    if (out_acc) begin
                        out_vld_q <= 1'b0;
                        if (!drain_end) buf_rd_q <= 1'b1;
                    end
                end
`ifdef RSA_STAGER_TIMEOUT_EN
                ST_ABORT: begin
                    if (ctl_wr_done) ctl_wr_q <= 1'b0;
                end
`endif
                default: begin
                    buf_wr_q  <= 1'b0;
                    buf_rd_q  <= 1'b0;
                    ctl_wr_q  <= 1'b0;
                    ctl_rd_q  <= 1'b0;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Host-side handshakes and status. The parked LOAD case (strobe low) keeps
    // the input open so the job can resume once the host supplies a word.
    always_comb begin
        s_in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: s_in_ready = 1'b1;
                ST_LOAD: s_in_ready = ~buf_wr_q |
                                      (buf_wr_done & (pk_idx == 2'd3) & ~last_byte);
                default: s_in_ready = 1'b0;
            endcase
        end
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DRAIN) & out_acc & drain_end;
    end

    assign s_out_data      = pk_word;
    assign s_out_valid     = out_vld_q;
    assign m_buf_address   = addr_q;
    assign m_buf_read      = buf_rd_q;
    assign m_buf_write     = buf_wr_q;
    assign m_buf_writedata = pk_byte;
    assign m_ctl_address   = FLAG_ADDR;
    assign m_ctl_read      = ctl_rd_q;
    assign m_ctl_write     = ctl_wr_q;
    assign m_ctl_writedata = ctl_wdata_q;

endmodule

// File: tb/tb_rsa_host_stager.sv
// Randomized bench for rsa_host_stager: models host source/sink, the byte
// buffer and the engine flag register, and checks every transfer against
// the job the bench itself submitted.
module tb_rsa_host_stager;

    localparam int BB = 320;
    localparam int NW = BB / 4;
    localparam int PG = 16;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_in_data = '0;
    logic        s_in_valid = 1'b0, s_in_ready;
    logic [31:0] s_out_data;
    logic        s_out_valid, s_out_ready = 1'b0;
    logic [31:0] m_buf_address;
    logic        m_buf_read, m_buf_write;
    logic [7:0]  m_buf_writedata, m_buf_readdata = '0;
    logic        m_buf_waitrequest = 1'b0;
    logic        m_ctl_address, m_ctl_read, m_ctl_write;
    logic [7:0]  m_ctl_writedata, m_ctl_readdata = '0;
    logic        m_ctl_waitrequest = 1'b0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    rsa_host_stager #(.BUF_BYTES(BB), .POLL_GAP(PG), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
        .s_out_data(s_out_data), .s_out_valid(s_out_valid), .s_out_ready(s_out_ready),
        .m_buf_address(m_buf_address), .m_buf_read(m_buf_read), .m_buf_write(m_buf_write),
        .m_buf_writedata(m_buf_writedata), .m_buf_readdata(m_buf_readdata),
        .m_buf_waitrequest(m_buf_waitrequest),
        .m_ctl_address(m_ctl_address), .m_ctl_read(m_ctl_read), .m_ctl_write(m_ctl_write),
        .m_ctl_writedata(m_ctl_writedata), .m_ctl_readdata(m_ctl_readdata),
        .m_ctl_waitrequest(m_ctl_waitrequest),
        .busy(busy), .done(done), .err(err)
    );

    int n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // job configuration
    int         stall_pct = 0, rdy_hold = 0, polls_busy = 0;
    logic [7:0] key = 8'h00;
    bit         run_en = 1'b0;

    // reference job and environment state
    logic [31:0] ref_w [NW];
    logic [31:0] in_q [$];
    logic [7:0]  mem [BB];
    int wr_cnt, rd_cnt, out_cnt, done_cnt, err_cnt, ctl_wr_cnt, ctl_rd_cnt;
    int idle_gap, out_wait;
    bit junk_en, junk_drv, busy_chk_nxt;
    bit prev_bw_st, prev_br_st, prev_cw_st, prev_ctl_rd;
    logic [63:0] prev_bw, prev_br, prev_cw;

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = ref_w[i / 4];
        return w[8 * (i % 4) +: 8];
    endfunction

    task automatic drive_inputs();
        m_buf_waitrequest = ($urandom_range(99) < stall_pct);
        m_ctl_waitrequest = ($urandom_range(99) < stall_pct / 2);
        if (m_buf_address < 32'(BB)) m_buf_readdata = mem[int'(m_buf_address)] ^ key;
        else                         m_buf_readdata = 8'h00;
        m_ctl_readdata = {7'd0, (ctl_rd_cnt < polls_busy)};
        junk_drv = 1'b0;
        if (in_q.size() > 0 && $urandom_range(3) != 0) begin
            s_in_valid = 1'b1;
            s_in_data  = in_q[0];
        end else if (junk_en && $urandom_range(1) == 1) begin
            s_in_valid = 1'b1;
            s_in_data  = $urandom;
            junk_drv   = 1'b1;
        end else begin
            s_in_valid = 1'b0;
            s_in_data  = $urandom;
        end
        s_out_ready = s_out_valid && (out_wait >= rdy_hold);
    endtask

    task automatic sample_outputs();
        // requests must hold steady across a stall
        if (prev_bw_st) check("wr_hold", {23'd0, m_buf_write, m_buf_address, m_buf_writedata}, prev_bw);
        if (prev_br_st) check("rd_hold", {31'd0, m_buf_read, m_buf_address}, prev_br);
        if (prev_cw_st) check("ctl_hold", {55'd0, m_ctl_write, m_ctl_writedata}, prev_cw);
        prev_bw_st = m_buf_write && m_buf_waitrequest;
        prev_br_st = m_buf_read && m_buf_waitrequest;
        prev_cw_st = m_ctl_write && m_ctl_waitrequest;
        prev_bw = {23'd0, m_buf_write, m_buf_address, m_buf_writedata};
        prev_br = {31'd0, m_buf_read, m_buf_address};
        prev_cw = {55'd0, m_ctl_write, m_ctl_writedata};

        if (m_buf_write || m_buf_read || m_ctl_write || m_ctl_read || s_out_valid)
            check("busy_on", 64'(busy), 64'd1);

        if (m_buf_write && !m_buf_waitrequest) begin
            check("wr_addr", 64'(m_buf_address), 64'(wr_cnt));
            check("wr_data", 64'(m_buf_writedata), (wr_cnt < BB) ? 64'(exp_byte(wr_cnt)) : 64'hDEAD);
            if (m_buf_address < 32'(BB)) mem[int'(m_buf_address)] = m_buf_writedata;
            wr_cnt++;
        end
        if (m_buf_read && !m_buf_waitrequest) begin
            check("rd_addr", 64'(m_buf_address), 64'(rd_cnt));
            rd_cnt++;
        end
        if (s_out_valid && !s_out_ready) check("rd_blocked", 64'(m_buf_read), 64'd0);

        if (m_ctl_write || m_ctl_read) check("ctl_addr", 64'(m_ctl_address), 64'd0);
        if (m_ctl_write && !m_ctl_waitrequest) begin
            check("ctl_wdata", 64'(m_ctl_writedata), (ctl_wr_cnt == 0) ? 64'h01 : 64'h00);
            if (ctl_wr_cnt == 0) check("kick_after_load", 64'(wr_cnt), 64'(BB));
            ctl_wr_cnt++;
            idle_gap = 0;
            junk_en  = 1'b1;
        end
        if (m_ctl_read) begin
            if (!prev_ctl_rd) check("poll_gap", 64'(idle_gap >= PG), 64'd1);
            if (!m_ctl_waitrequest) begin
                ctl_rd_cnt++;
                idle_gap = 0;
            end
        end else if (!m_ctl_write) begin
            idle_gap++;
        end
        prev_ctl_rd = m_ctl_read && m_ctl_waitrequest;

        if (junk_drv) check("in_refused", 64'(s_in_ready), 64'd0);
        else if (s_in_valid && s_in_ready && in_q.size() > 0) void'(in_q.pop_front());

        if (s_out_valid && s_out_ready) begin
            if (out_cnt < NW) check("out_word", 64'(s_out_data), 64'(ref_w[out_cnt] ^ {4{key}}));
            else              check("out_extra", 64'(out_cnt), 64'(NW - 1));
            out_cnt++;
            out_wait = 0;
        end else if (s_out_valid) begin
            out_wait++;
        end

        if (busy_chk_nxt) begin
            check("busy_after_done", 64'(busy), 64'd0);
            busy_chk_nxt = 1'b0;
        end
        if (done) begin
            check("done_on_last", 64'(out_cnt), 64'(NW));
            done_cnt++;
            busy_chk_nxt = 1'b1;
            junk_en = 1'b0;
        end
        if (err) begin
            err_cnt++;
            junk_en = 1'b0;
        end
    endtask

    // environment: drive on the falling edge, sample just after
    initial begin
        forever begin
            @(negedge clk);
            drive_inputs();
            #1;
            if (!reset && run_en) sample_outputs();
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_data"}, {s_out_data, m_buf_address}, 64'd0);
        check({tag, "_ctl"}, {40'd0, s_in_ready, s_out_valid, m_buf_read, m_buf_write,
                              m_ctl_read, m_ctl_write, busy, done, err, m_ctl_address,
                              m_buf_writedata, m_ctl_writedata}, 64'd0);
    endtask

    task automatic start_job(input int st, input int hold, input int polls,
                             input logic [7:0] k, input bit rnd);
        stall_pct = st; rdy_hold = hold; polls_busy = polls; key = k;
        in_q.delete();
        for (int w = 0; w < NW; w++) begin
            if (rnd) ref_w[w] = $urandom;
            else     ref_w[w] = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
            in_q.push_back(ref_w[w]);
        end
        wr_cnt = 0; rd_cnt = 0; out_cnt = 0; done_cnt = 0; err_cnt = 0;
        ctl_wr_cnt = 0; ctl_rd_cnt = 0; idle_gap = 0; out_wait = 0;
        junk_en = 0; busy_chk_nxt = 0;
        prev_bw_st = 0; prev_br_st = 0; prev_cw_st = 0; prev_ctl_rd = 0;
        run_en = 1'b1;
    endtask

    task automatic finish_job(input bit expect_to);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < 30000 && !fin; c++) begin
            @(negedge clk); #2;
            fin = expect_to ? (err_cnt > 0 && ctl_wr_cnt >= 2 && !busy)
                            : (done_cnt > 0 && !busy);
        end
        check("job_finished", 64'(fin), 64'd1);
        repeat (4) @(negedge clk);
        #2;
        check("tot_writes", 64'(wr_cnt), 64'(BB));
        check("tot_ctl_wr", 64'(ctl_wr_cnt), expect_to ? 64'd2 : 64'd1);
        check("tot_reads", 64'(rd_cnt), expect_to ? 64'd0 : 64'(BB));
        check("tot_words", 64'(out_cnt), expect_to ? 64'd0 : 64'(NW));
        check("tot_done", 64'(done_cnt), expect_to ? 64'd0 : 64'd1);
        check("tot_err", 64'(err_cnt), expect_to ? 64'd1 : 64'd0);
        if (!expect_to) check("tot_polls", 64'(ctl_rd_cnt), 64'(polls_busy + 1));
        check("idle_busy", 64'(busy), 64'd0);
        run_en = 1'b0;
    endtask

    initial begin
        bit hit;
        for (int a = 0; a < BB; a++) mem[a] = 8'h00;
        repeat (2) @(negedge clk);
        #2;
        check_reset_outs("reset");
        @(posedge clk); #2 reset = 1'b0;

        // ordered load pattern, no stalls, 5 busy polls
        start_job(0, 0, 5, 8'h00, 1'b0);
        finish_job(1'b0);
        // random data with 50% buffer stalls
        start_job(50, 0, 5, 8'h00, 1'b1);
        finish_job(1'b0);
        // drain backpressure, buffer returns a^A5
        start_job(0, 10, 5, 8'hA5, 1'b0);
        finish_job(1'b0);
        // engine already finished at the first poll
        start_job(30, 3, 0, 8'h5A, 1'b1);
        finish_job(1'b0);

        // reset in the middle of LOAD, then a clean job
        start_job(20, 2, 2, 8'h3C, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 5000 && !hit; c++) begin
            @(negedge clk); #2;
            hit = (wr_cnt >= 150);
        end
        check("reach_byte150", 64'(hit), 64'd1);
        @(posedge clk); #2;
        reset = 1'b1; run_en = 1'b0;
        #1;
        check_reset_outs("midjob_reset");
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset = 1'b0;
        start_job(20, 2, 2, 8'h3C, 1'b1);
        finish_job(1'b0);

`ifdef RSA_STAGER_TIMEOUT_EN
        // engine never clears the flag
        start_job(10, 0, 1000000, 8'h00, 1'b1);
        finish_job(1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
